// File: rtl/hvac_actuator_ctrl_if.sv
// Demand inputs and actuator outputs between the air-con controller and the actuator stage.
interface hvac_actuator_ctrl_if;
    logic       heating;
    logic       cooling;
    logic       heater_on;
    logic       cooler_on;
    logic       fan_on;
    logic [1:0] mode;
    logic       fault;

    modport master (
        output heating, cooling,
        input  heater_on, cooler_on, fan_on, mode, fault
    );

    modport slave (
        input  heating, cooling,
        output heater_on, cooler_on, fan_on, mode, fault
    );
endinterface

// File: rtl/hvac_actuator_ctrl.sv
// Heater/compressor/fan sequencer with a minimum run time per mode and a fan-only lockout
// between active modes; both demands high is latched as a fault and treated as no demand.
module hvac_actuator_ctrl #(
    parameter int MIN_ON_CYCLES  = 4,
    parameter int MIN_OFF_CYCLES = 3,
    parameter int CNT_W          = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    hvac_actuator_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HEAT    = 2'b01,
        COOL    = 2'b10,
        LOCKOUT = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MIN_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (MIN_ON_CYCLES < 1 || MIN_ON_CYCLES > 255) begin : g_bad_on
        $error("hvac_actuator_ctrl: MIN_ON_CYCLES out of range 1..255");
    end
    if (MIN_OFF_CYCLES < 1 || MIN_OFF_CYCLES > 255) begin : g_bad_off
        $error("hvac_actuator_ctrl: MIN_OFF_CYCLES out of range 1..255");
    end

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             fault_reg, fault_next;
    logic             heat_req, cool_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            fault_reg <= fault_next;
        end
    end

    always_comb begin
        heat_req   = bus.heating & ~bus.cooling;
        cool_req   = bus.cooling & ~bus.heating;
        fault_next = fault_reg | (bus.heating & bus.cooling);
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (heat_req) begin
                    state_next = HEAT;
                end else if (cool_req) begin
                    state_next = COOL;
                end
            end
            HEAT: begin
                // Counter parks at ON_LAST so the exit decision is taken on the first idle edge.
                if (cnt_reg == ON_LAST) begin
                    if (!heat_req) begin
                        state_next = LOCKOUT;
                        cnt_next   = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            COOL: begin
                if (cnt_reg == ON_LAST) begin
                    if (!cool_req) begin
                        state_next = LOCKOUT;
                        cnt_next   = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                if (cnt_reg == OFF_LAST) begin
                    cnt_next = '0;
                    if (heat_req) begin
                        state_next = HEAT;
                    end else if (cool_req) begin
                        state_next = COOL;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
        endcase
    end

    always_comb begin
        bus.heater_on = (state_reg == HEAT);
        bus.cooler_on = (state_reg == COOL);
        bus.fan_on    = (state_reg != IDLE);
        bus.mode      = state_reg;
        bus.fault     = fault_reg;
    end

endmodule

// File: tb/tb_hvac_actuator_ctrl.sv
// Scenario bench for hvac_actuator_ctrl: expected actuator vectors are queued when demand is
// driven and compared after the edge that should produce them.
module tb_hvac_actuator_ctrl;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [5:0] sb[$];

    hvac_actuator_ctrl_if dif();

    hvac_actuator_ctrl #(
        .MIN_ON_CYCLES (4),
        .MIN_OFF_CYCLES(3),
        .CNT_W         (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (dif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {heater_on, cooler_on, fan_on, mode[1:0], fault} expected for a given mode
    function automatic logic [5:0] exp_vec(input logic [1:0] m, input logic f);
        return {(m == 2'd1), (m == 2'd2), (m != 2'd0), m, f};
    endfunction

    function automatic logic [5:0] obs_vec();
        return {dif.heater_on, dif.cooler_on, dif.fan_on, dif.mode, dif.fault};
    endfunction

    always @(negedge clk) begin
        checks++;
        if ((dif.heater_on & dif.cooler_on) === 1'b1 ||
            ((dif.heater_on | dif.cooler_on) === 1'b1 && dif.fan_on !== 1'b1)) begin
            errors++;
            $display("FAIL invariant t=%0t heater=%b cooler=%b fan=%b", $time,
                     dif.heater_on, dif.cooler_on, dif.fan_on);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        dif.heating = 1'b0;
        dif.cooling = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] e, o;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(exp_vec(2'd0, 1'b0));
            @(posedge clk); #1;
            e = sb.pop_front(); o = obs_vec(); checks++;
            $display("reset[%0d] rst_n=0 heating=1 obs=%b exp=%b", i, o, e);
            if (o !== e) begin errors++; $display("FAIL reset_hold[%0d] got=%b want=%b", i, o, e); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        dif.heating = 1'b1;
        sb.push_back(exp_vec(2'd1, 1'b0));
        @(posedge clk); #1;
        e = sb.pop_front(); o = obs_vec(); checks++;
        $display("reset_release heating=1 obs=%b exp=%b", o, e);
        if (o !== e) begin errors++; $display("FAIL reset_release got=%b want=%b", o, e); end
    endtask

    task automatic test_short_pulse();
        logic [1:0] stim [9] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [1:0] em   [9] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
        logic [5:0] e, o;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            dif.heating = stim[i][1]; dif.cooling = stim[i][0];
            sb.push_back(exp_vec(em[i], 1'b0));
            @(posedge clk); #1;
            e = sb.pop_front(); o = obs_vec(); checks++;
            $display("short[%0d] hc=%b obs=%b exp=%b", i, stim[i], o, e);
            if (o !== e) begin errors++; $display("FAIL short[%0d] got=%b want=%b", i, o, e); end
        end
    endtask

    task automatic test_long_demand();
        logic [1:0] m;
        logic [5:0] e, o;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            m = (i < 10) ? 2'd1 : (i < 13) ? 2'd3 : 2'd0;
            @(negedge clk);
            dif.heating = (i < 10); dif.cooling = 1'b0;
            sb.push_back(exp_vec(m, 1'b0));
            @(posedge clk); #1;
            e = sb.pop_front(); o = obs_vec(); checks++;
            $display("long[%0d] h=%b obs=%b exp=%b", i, dif.heating, o, e);
            if (o !== e) begin errors++; $display("FAIL long[%0d] got=%b want=%b", i, o, e); end
        end
    endtask

    task automatic test_mode_swap();
        logic [1:0] stim [17] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                                  2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                                  2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [1:0] em   [17] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                  2'd3, 2'd3, 2'd3, 2'd1, 2'd1, 2'd1,
                                  2'd1, 2'd3, 2'd3, 2'd3, 2'd0};
        logic [5:0] e, o;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            dif.heating = stim[i][1]; dif.cooling = stim[i][0];
            sb.push_back(exp_vec(em[i], 1'b0));
            @(posedge clk); #1;
            e = sb.pop_front(); o = obs_vec(); checks++;
            $display("swap[%0d] hc=%b obs=%b exp=%b", i, stim[i], o, e);
            if (o !== e) begin errors++; $display("FAIL swap[%0d] got=%b want=%b", i, o, e); end
        end
    endtask

    task automatic test_illegal();
        logic [1:0] stim [10] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11,
                                  2'b00, 2'b00, 2'b00, 2'b00};
        logic [1:0] em   [10] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3,
                                  2'd3, 2'd3, 2'd0, 2'd0};
        logic [5:0] e, o;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dif.heating = stim[i][1]; dif.cooling = stim[i][0];
            sb.push_back(exp_vec(em[i], 1'b1));
            @(posedge clk); #1;
            e = sb.pop_front(); o = obs_vec(); checks++;
            $display("illegal[%0d] hc=%b obs=%b exp=%b", i, stim[i], o, e);
            if (o !== e) begin errors++; $display("FAIL illegal[%0d] got=%b want=%b", i, o, e); end
        end
        @(negedge clk);
        rst_n = 1'b0;
        sb.push_back(exp_vec(2'd0, 1'b0));
        #1;
        e = sb.pop_front(); o = obs_vec(); checks++;
        $display("illegal_clear rst_n=0 obs=%b exp=%b", o, e);
        if (o !== e) begin errors++; $display("FAIL fault_clear got=%b want=%b", o, e); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_async_reset();
        logic [5:0] e, o;
        do_reset();
        @(negedge clk);
        dif.heating = 1'b1; dif.cooling = 1'b0;
        sb.push_back(exp_vec(2'd1, 1'b0));
        @(posedge clk); #1;
        e = sb.pop_front(); o = obs_vec(); checks++;
        $display("async_heat obs=%b exp=%b", o, e);
        if (o !== e) begin errors++; $display("FAIL async_heat got=%b want=%b", o, e); end
        #2;
        rst_n = 1'b0;
        sb.push_back(exp_vec(2'd0, 1'b0));
        #1;
        e = sb.pop_front(); o = obs_vec(); checks++;
        $display("async_assert mid-period obs=%b exp=%b", o, e);
        if (o !== e) begin errors++; $display("FAIL async_clear got=%b want=%b", o, e); end
        @(negedge clk);
        rst_n = 1'b1;
        dif.heating = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(exp_vec(2'd0, 1'b0));
            @(posedge clk); #1;
            e = sb.pop_front(); o = obs_vec(); checks++;
            $display("async_release[%0d] obs=%b exp=%b", i, o, e);
            if (o !== e) begin errors++; $display("FAIL async_no_lockout[%0d] got=%b want=%b", i, o, e); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        dif.heating = 1'b1;
        dif.cooling = 1'b0;
        test_reset();
        test_short_pulse();
        test_long_demand();
        test_mode_swap();
        test_illegal();
        test_async_reset();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
